// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus arbiter and the device-side blocks:
// arbiter state encoding and the active-low signal levels used on the bus.
package pci_pkg;

    // Width of the arbiter state encoding.
    localparam int STATE_W = 2;

    // Arbiter phases: waiting for requests, granted but no frame yet,
    // transaction in flight, and the one-cycle bus turnaround.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    // PCI control signals are active low.
    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    // True when an active-low control line is driven to its active level.
    function automatic logic is_asserted(input logic sig);
        return sig == ASSERTED;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search over active-low request lines. The search starts
// at the device after the last winner and wraps, so the last winner has the
// lowest priority.
module rr_picker
    import pci_pkg::*;
#(
    parameter int NUM_DEV = 4,
    parameter int IDX_W   = $clog2(NUM_DEV)
) (
    input  logic [NUM_DEV-1:0] req_vec,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    // Walk the devices from last+1 upward, taking the first active request.
    always_comb begin
        int cand;
        // NOTE: every output gets a default before the search so that no path
        // through the loop leaves it unassigned, which would infer a latch.
        win_idx   = last;
        win_valid = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_DEV; off++) begin
            cand = int'(last) + off;
            if (cand >= NUM_DEV) begin
                cand = cand - NUM_DEV;
            end
            if (!win_valid && is_asserted(req_vec[cand[IDX_W-1:0]])) begin
                win_valid = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant among NUM_DEV devices, grant
// timeout when the winner never starts a frame, release on request removal,
// and a single turnaround cycle between bus owners.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int NUM_DEV     = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_DEV-1:0]         request,
    input  logic                       iframe,
    input  logic                       iready,
    output logic [NUM_DEV-1:0]         grant,
    output logic [$clog2(NUM_DEV)-1:0] owner,
    output logic                       bus_idle
);

    localparam int OWN_W = $clog2(NUM_DEV);
    localparam int TMR_W = $clog2(GNT_TIMEOUT + 1);

    // Device 0 wins first after reset because the search starts at owner+1.
    localparam logic [OWN_W-1:0]   OWNER_RST  = OWN_W'(NUM_DEV - 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(GNT_TIMEOUT);
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(1);
    localparam logic [NUM_DEV-1:0] GRANT_NONE = {NUM_DEV{DEASSERTED}};

    arb_state_t         state;
    logic [TMR_W-1:0]   timer;

    logic [OWN_W-1:0]   win_idx;
    logic               win_valid;
    logic [NUM_DEV-1:0] win_grant;
    logic               owner_req;
    logic               frame_start;
    logic               bus_quiet;

    rr_picker #(
        .NUM_DEV (NUM_DEV),
        .IDX_W   (OWN_W)
    ) u_picker (
        .req_vec   (request),
        .last      (owner),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // Decode the winner into a grant vector and qualify the bus conditions.
    always_comb begin
        win_grant          = GRANT_NONE;
        win_grant[win_idx] = ASSERTED;
        owner_req          = is_asserted(request[owner]);
        frame_start        = is_asserted(iframe);
        bus_quiet          = (iframe == DEASSERTED) && (iready == DEASSERTED);
    end

    // Arbitration FSM; grant, owner and bus_idle are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= GRANT_NONE;
            owner    <= OWNER_RST;
            bus_idle <= 1'b1;
            timer    <= TMR_LOAD;
        end else begin
            // NOTE: non-blocking assignments so every branch reads the state
            // as it was before this edge, matching real flip-flop behaviour.
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant    <= win_grant;
                        owner    <= win_idx;
                        bus_idle <= 1'b0;
                        timer    <= TMR_LOAD;
                        state    <= GRANT;
                    end
                end

                GRANT: begin
                    if (frame_start) begin
                        // A started frame wins over withdrawal and timeout.
                        timer <= TMR_LOAD;
                        state <= BUSY;
                    end else if (!owner_req) begin
                        grant <= GRANT_NONE;
                        timer <= TMR_LOAD;
                        state <= TURN;
                    end else if (timer == TMR_LAST) begin
                        // Counter reaches zero on this edge: give the bus up.
                        grant <= GRANT_NONE;
                        timer <= TMR_LOAD;
                        state <= TURN;
                    end else begin
                        timer <= timer - TMR_LAST;
                    end
                end

                BUSY: begin
                    if (bus_quiet) begin
                        grant <= GRANT_NONE;
                        state <= TURN;
                    end else if (!owner_req) begin
                        // Grant drops early but the current frame must drain.
                        grant <= GRANT_NONE;
                    end
                end

                TURN: begin
                    grant    <= GRANT_NONE;
                    bus_idle <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    grant    <= GRANT_NONE;
                    bus_idle <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_DEV, default 4, giving the number of bus devices (2..8).
REQ-002 The block SHALL have parameter GNT_TIMEOUT, default 16, giving the cycles a granted device has to assert iframe.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port request, input, NUM_DEV, per-device bus request, active low.
REQ-006 The block SHALL have port iframe, input, 1, shared bus frame, active low.
REQ-007 The block SHALL have port iready, input, 1, shared initiator ready, active low.
REQ-008 The block SHALL have port grant, output, NUM_DEV, per-device grant, active low, registered.
REQ-009 The block SHALL have port owner, output, clog2(NUM_DEV), index of the current or last granted device.
REQ-010 The block SHALL have port bus_idle, output, 1, high when the FSM is in IDLE.

Function
REQ-011 The FSM SHALL have four states: IDLE, GRANT, BUSY, TURN.
REQ-012 At most one grant bit SHALL be low in any cycle; grant SHALL be all ones in IDLE and TURN.
REQ-013 In IDLE with any request bit low, arbitration SHALL be round-robin: first low request searching upward from owner+1, wrapping from NUM_DEV-1 to 0.
REQ-014 The winner's grant SHALL go low on the next posedge (1-cycle latency), owner SHALL update to it, and the FSM SHALL enter GRANT.
REQ-015 In IDLE with all requests high, grant SHALL stay all ones and owner SHALL hold.
REQ-016 In GRANT, iframe low SHALL move the FSM to BUSY with the grant held.
REQ-017 In GRANT, if the owner's request goes high before iframe goes low, grant SHALL be released next cycle and the FSM SHALL enter TURN.
REQ-018 In GRANT, a down-counter loaded with GNT_TIMEOUT SHALL decrement every cycle; at zero without iframe low, grant SHALL be released and the FSM SHALL enter TURN.
REQ-019 In BUSY, the owner's grant SHALL be held while its request is low.
REQ-020 In BUSY, if the owner's request goes high, grant SHALL be released; the FSM SHALL stay in BUSY until the bus is idle.
REQ-021 In BUSY, the bus is idle when iframe and iready are both high on the same posedge; the FSM SHALL then enter TURN.
REQ-022 TURN SHALL last exactly one cycle with all grants high, then go to IDLE; requests seen in TURN SHALL be ignored.
REQ-023 If a device holds request low continuously, it SHALL never be re-granted while another device's request is low (fairness).
REQ-024 Simultaneous requests in IDLE SHALL be resolved only by the round-robin order from owner+1.
REQ-025 Request bits SHALL be sampled only in IDLE; changes in other states SHALL not alter owner.

Reset
REQ-026 When rst_n is low, the block SHALL immediately set grant to all ones, owner to NUM_DEV-1 (so device 0 has first priority), bus_idle to 1, state to IDLE and the timeout counter to GNT_TIMEOUT.
REQ-027 Reset asserted mid-transaction SHALL drop the grant asynchronously, with no TURN cycle required.
REQ-028 The block SHALL evaluate its first arbitration on the first posedge after rst_n rises.

Structure
REQ-029 The state enum, the state encoding width and the active-low ASSERTED/DEASSERTED constants SHALL live in shared package pci_pkg, which the device block also uses.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_picker, with inputs req_vec and last and outputs win_idx and win_valid.

Verification
REQ-031 Scenario: reset, then request=4'b1110 -> grant=4'b1110 one cycle later, owner=0, bus_idle=0.
REQ-032 Scenario: owner=0, all four requests low in IDLE -> grant order 1, 2, 3, 0 across four complete iframe transactions.
REQ-033 Scenario: device 2 is granted and iframe stays high -> grant released after 16 cycles, TURN lasts 1 cycle, then IDLE.
REQ-034 Scenario: in BUSY, the owner drops its request while iframe is low -> grant goes high next cycle; the FSM stays in BUSY until iframe=iready=1, then TURN, then the next device is granted.
REQ-035 Scenario: rst_n driven low mid-BUSY -> grant=all ones with no clock edge, owner=NUM_DEV-1.
REQ-036 Every test SHALL check that at most one grant bit is low in every cycle.
